// File: rtl/keccak_pkg.sv
// Shared constants, state encoding and byte addressing for the SHA3 sponge.
// Byte k of the sponge state sits at bits [1599-8k -: 8].
package keccak_pkg;

    localparam int STATE_W = 1600;
    localparam logic [7:0] SHA3_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_LAST = 8'h80;

    typedef enum logic [2:0] {
        ST_ABSORB,
        ST_PAD,
        ST_PERM_REQ,
        ST_PERM_WAIT,
        ST_OUT
    } sponge_st_e;

    function automatic int byte_msb(input int k);
        return STATE_W - 1 - 8 * k;
    endfunction

endpackage

// File: rtl/keccak_pad_mask.sv
// Builds the XOR mask for one absorbed word: masked message bytes placed at
// word slot w, plus the SHA3 domain byte and final 0x80 when padding lands.
module keccak_pad_mask
    import keccak_pkg::*;
#(
    parameter int RATE_WORDS = 17,
    parameter logic [7:0] DOMAIN_BYTE = SHA3_DOMAIN
) (
    input  logic [4:0]         i_w,
    input  logic [3:0]         i_nbytes,
    input  logic [63:0]        i_data,
    input  logic               i_last,
    input  logic               i_pad_only,
    output logic               o_fits,
    output logic [STATE_W-1:0] o_mask
);

    localparam logic [4:0] W_LAST = 5'(RATE_WORDS - 1);
    localparam int END_LSB = byte_msb(8 * RATE_WORDS - 1) - 7;
    localparam logic [STATE_W-1:0] END_MASK =
        {{(STATE_W - 8){1'b0}}, PAD_LAST} << END_LSB;

    logic [3:0]         w_nb;
    logic [63:0]        w_keep;
    logic [10:0]        w_dom_sh;
    logic [STATE_W-1:0] w_msg;
    logic [STATE_W-1:0] w_dom;
    logic               w_pad;

    // Oversized byte counts saturate to a full word
    assign w_nb = (i_nbytes > 4'd8) ? 4'd8 : i_nbytes;
    assign w_keep = ~(64'hFFFF_FFFF_FFFF_FFFF >> {w_nb, 3'b000});
    assign w_dom_sh = i_pad_only ? 11'd0
                    : ({i_w, 6'b0} + {4'b0, w_nb, 3'b0});

    assign w_msg = {i_data & w_keep, {(STATE_W - 64){1'b0}}} >> {i_w, 6'b0};
    assign w_dom = {DOMAIN_BYTE, {(STATE_W - 8){1'b0}}} >> w_dom_sh;

    assign o_fits = (w_nb != 4'd8) || (i_w != W_LAST);
    assign w_pad = i_pad_only || (i_last && o_fits);

    assign o_mask = (i_pad_only ? '0 : w_msg)
                  ^ (w_pad ? (w_dom ^ END_MASK) : '0);

endmodule

// File: rtl/keccak_sponge_absorb.sv
// SHA3 sponge front end: absorbs 64-bit words, pads, drives the permutation
// handshake and presents the digest. Owns the sponge state between calls.
module keccak_sponge_absorb
    import keccak_pkg::*;
#(
    parameter int RATE_WORDS = 17,
    parameter int DIGEST_BITS = 256,
    parameter logic [7:0] DOMAIN_BYTE = SHA3_DOMAIN
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [63:0]            i_msg_data,
    input  logic [3:0]             i_msg_nbytes,
    input  logic                   i_msg_last,
    input  logic                   i_msg_valid,
    output logic                   o_msg_ready,
    output logic [STATE_W-1:0]     o_perm_state,
    output logic                   o_perm_valid,
    input  logic                   i_perm_ready,
    input  logic [STATE_W-1:0]     i_perm_state,
    input  logic                   i_perm_valid,
    output logic [DIGEST_BITS-1:0] o_digest,
    output logic                   o_digest_valid,
    input  logic                   i_digest_ready
);

    localparam logic [4:0] W_LAST = 5'(RATE_WORDS - 1);

    sponge_st_e         r_fsm;
    sponge_st_e         w_nxt;
    logic [STATE_W-1:0] r_state;
    logic [4:0]         r_w;
    logic               r_final;
    logic               r_pad_pend;

    logic               w_acc;
    logic               w_pad_only;
    logic               w_fits;
    logic [STATE_W-1:0] w_mask;

    assign w_acc = i_msg_valid && (r_fsm == ST_ABSORB);
    assign w_pad_only = (r_fsm == ST_PAD);

    keccak_pad_mask #(
        .RATE_WORDS (RATE_WORDS),
        .DOMAIN_BYTE(DOMAIN_BYTE)
    ) u_mask (
        .i_w       (r_w),
        .i_nbytes  (i_msg_nbytes),
        .i_data    (i_msg_data),
        .i_last    (i_msg_last),
        .i_pad_only(w_pad_only),
        .o_fits    (w_fits),
        .o_mask    (w_mask)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_fsm <= ST_ABSORB;
        else       r_fsm <= w_nxt;
    end

    always_comb begin
        w_nxt = r_fsm;
        unique case (r_fsm)
            ST_ABSORB: begin
                if (w_acc && (i_msg_last || r_w == W_LAST))
                    w_nxt = ST_PERM_REQ;
            end
            ST_PAD: w_nxt = ST_PERM_REQ;
            ST_PERM_REQ: begin
                if (i_perm_ready) w_nxt = ST_PERM_WAIT;
            end
            ST_PERM_WAIT: begin
                if (i_perm_valid) begin
                    if (r_final)         w_nxt = ST_OUT;
                    else if (r_pad_pend) w_nxt = ST_PAD;
                    else                 w_nxt = ST_ABSORB;
                end
            end
            ST_OUT: begin
                if (i_digest_ready) w_nxt = ST_ABSORB;
            end
            default: w_nxt = ST_ABSORB;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= '0;
            r_w        <= '0;
            r_final    <= 1'b0;
            r_pad_pend <= 1'b0;
        end else begin
            unique case (r_fsm)
                ST_ABSORB: begin
                    if (w_acc) begin
                        r_state <= r_state ^ w_mask;
                        if (i_msg_last) begin
                            r_w        <= '0;
                            r_final    <= w_fits;
                            r_pad_pend <= !w_fits;
                        end else begin
                            r_w     <= (r_w == W_LAST) ? 5'd0 : r_w + 5'd1;
                            r_final <= 1'b0;
                        end
                    end
                end
                ST_PAD: begin
                    r_state <= r_state ^ w_mask;
                    r_final <= 1'b1;
                end
                ST_PERM_WAIT: begin
                    if (i_perm_valid) begin
                        r_state <= i_perm_state;
                        if (!r_final) r_pad_pend <= 1'b0;
                    end
                end
                ST_OUT: begin
                    if (i_digest_ready) begin
                        r_state    <= '0;
                        r_w        <= '0;
                        r_final    <= 1'b0;
                        r_pad_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_msg_ready    = (r_fsm == ST_ABSORB);
        o_perm_valid   = (r_fsm == ST_PERM_REQ);
        o_digest_valid = (r_fsm == ST_OUT);
        o_perm_state   = r_state;
        o_digest       = '0;
        if (r_fsm == ST_OUT) o_digest = r_state[STATE_W-1 -: DIGEST_BITS];
    end

endmodule

// File: doc/keccak_sponge_absorb.md
# keccak_sponge_absorb

SHA3-256 sponge front end for the Keccak-f[1600] permutation core. It accepts a byte-aligned message as a stream of 64-bit words and XORs each word into a 1600-bit state register. It applies SHA3 padding, hands each full rate block to the permutation over a valid/ready handshake, and presents the 256-bit digest on a valid/ready output. It sits directly upstream of the permutation core and owns the only copy of the sponge state between permutation calls.

## Interface
- RATE_WORDS, 17: rate in 64-bit words (136 bytes, SHA3-256); legal range 1..21.
- DIGEST_BITS, 256: digest width; must be ≤ 64·RATE_WORDS.
- DOMAIN_BYTE, 8'h06: first padding byte (SHA3 domain separation).
- i_clk  in  1  clock, single clock domain.
- i_rst  in  1  reset, synchronous, active-high.
- i_msg_data  in  64  message word; first message byte in [63:56].
- i_msg_nbytes  in  4  valid bytes in the word, MSB-aligned; must be 8 unless i_msg_last; 0..8 when last.
- i_msg_last  in  1  final word of the message.
- i_msg_valid  in  1  word present.
- o_msg_ready  out  1  word accepted when valid & ready.
- o_perm_state  out  1600  state to the permutation; byte k of the sponge is at bits [1599-8k -: 8].
- o_perm_valid  out  1  permutation request.
- i_perm_ready  in  1  permutation accepts the request.
- i_perm_state  in  1600  permuted state, same byte layout.
- i_perm_valid  in  1  one-cycle pulse; i_perm_state is valid in that cycle.
- o_digest  out  DIGEST_BITS  digest; first digest byte in the MSB.
- o_digest_valid  out  1  digest present.
- i_digest_ready  in  1  digest consumed.

## Operation
**States:** ABSORB, PAD, PERM_REQ, PERM_WAIT, OUT. Reset enters ABSORB, clears the state register and the word counter, and clears the final/pad flags.

**Output values in reset (and in ABSORB):** o_msg_ready=1; o_perm_valid=0; o_digest_valid=0; o_digest=0.

**ABSORB**
- Ready is high. On each accepted word, XOR the word into state byte positions 8·w..8·w+7, with w = word counter (0..RATE_WORDS-1). Bytes beyond i_msg_nbytes are masked to zero.
- Non-last word, w < RATE_WORDS-1: w increments.
- Non-last word, w = RATE_WORDS-1: w wraps to 0; go to PERM_REQ with final=0.
- Last word, padding fits in this block (nbytes<8, or w<RATE_WORDS-1):
  - In the same cycle, XOR DOMAIN_BYTE at byte 8·w+nbytes and XOR 8'h80 at byte 8·RATE_WORDS-1.
  - If both land on the same byte, the result is 8'h86 (XOR).
  - Go to PERM_REQ with final=1.
- Last word, nbytes=8 and w=RATE_WORDS-1: go to PERM_REQ with final=0 and pad_pending=1.

**PAD**
- XOR DOMAIN_BYTE into byte 0 and 8'h80 into byte 8·RATE_WORDS-1 in one cycle.
- Set final=1; go to PERM_REQ.

**PERM_REQ**
- o_perm_valid=1 and o_perm_state = state register, held stable until i_perm_ready.
- On the transfer, go to PERM_WAIT.

**PERM_WAIT**
- On i_perm_valid, load the state register from i_perm_state.
- Next state: final → OUT; pad_pending → PAD (clear pad_pending); otherwise → ABSORB.

**OUT**
- o_digest_valid=1; o_digest = state bits [1599 -: DIGEST_BITS], held stable.
- On i_digest_ready, clear the state register, w, and the flags; return to ABSORB.

**Boundary rules**
- An empty message (last word with nbytes=0 at w=0) gives a single padding-only block.
- i_perm_valid outside PERM_WAIT is ignored.
- i_msg_nbytes>8 is treated as 8.
- Reset mid-operation discards all state, including an outstanding request. The permutation core is reset by the same i_rst.

## Timing
- The state update for an accepted word is visible on o_perm_state in the next cycle.
- o_perm_valid rises the cycle after the accept of the block-closing word, or the cycle after PAD.
- o_perm_valid deasserts the cycle after the valid&ready transfer.
- o_digest_valid rises the cycle after the final i_perm_valid.
- Throughput: one word per cycle within a block. Per block, the overhead is 1 request cycle plus the permutation latency.
- o_msg_ready=0 in every state except ABSORB; there is no combinational path from i_msg_valid to o_msg_ready.
- Simultaneous i_digest_ready and i_msg_valid in OUT: the word is not accepted; ready returns the next cycle.

## Structure
- Shared package keccak_pkg holds:
  - the STATE_W=1600 constant;
  - the byte-position function (byte k → bit 1599-8k);
  - SHA3 DOMAIN_BYTE and the 8'h80 pad constant;
  - the state enum.
- One combinational sub-module, keccak_pad_mask: from (w, nbytes, last, pad_only) it produces the 1600-bit XOR mask for message bytes plus padding. The FSM and state register stay in the top level.

## Test plan
- **Empty message:** one word, nbytes=0, last=1, with an ideal permutation model → one request, digest a7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a.
- **"abc":** word 64'h6162630000000000, nbytes=3, last → digest 3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532. Before the request, check byte 3 = 8'h06 and byte 135 = 8'h80.
- **135-byte message:** last word nbytes=7 at w=16 → byte 135 = 8'h86, exactly one permutation request.
- **136-byte message:** 17 full words, last on w=16 → two requests, with the second block equal to 06 00…00 80.
- **Backpressure:**
  - Hold i_perm_ready=0 for 5 cycles → o_perm_state and o_perm_valid stable throughout.
  - Hold i_digest_ready=0 for 4 cycles → digest stable.
  - i_perm_valid pulsed in ABSORB → no state change.
- **Reset mid-block:** assert i_rst after 9 words → next cycle o_msg_ready=1 and o_perm_valid=0. A subsequent "abc" gives the correct digest.
